quadrature_input_conditioner: RTL
=================================

# quadrature_input_conditioner

Front-end for the wheel encoder channels: synchronises the raw asynchronous A/B tachometer lines, rejects glitches shorter than a programmable window, and produces clean A/B levels that feed the edge counter directly. It also decodes the quadrature sequence into direction, single-step pulses and a signed position count, and flags illegal (double-bit) transitions.

## Interface
- FILTER_CYCLES, 16: consecutive samples at a new level required before a filtered output changes; legal range ≥1.
- POS_WIDTH, 32: width of the signed position counter.
- ERR_CNT_WIDTH, 8: width of the illegal-transition counter. Used only with the error counter compiled in.
- clk_in  input  1  125 MHz system clock.
- reset_in  input  1  asynchronous, active-high reset.
- tachometer_raw_a  input  1  raw encoder channel A, asynchronous.
- tachometer_raw_b  input  1  raw encoder channel B, asynchronous.
- tachometer_out_a  output  1  filtered channel A, which feeds the edge counter.
- tachometer_out_b  output  1  filtered channel B, which feeds the edge counter.
- dir_o  output  1  last legal direction: 1 = forward (A leads B), 0 = reverse.
- step_valid_o  output  1  one-cycle pulse per legal quadrature step.
- position_o  output  POS_WIDTH  signed step count, two's complement.
- illegal_o  output  1  one-cycle pulse per illegal transition.
- err_count_o  output  ERR_CNT_WIDTH  saturating illegal-transition count. Present only with QUAD_ERROR_COUNT_EN.

## Operation
- **Synchroniser:** each channel passes through two flops (sync1, sync2).
- **Glitch filter, per channel:**
  - Counter `cnt` compares sync2 against the filtered output.
  - When they are equal, `cnt` clears to 0.
  - When they differ and `cnt` = FILTER_CYCLES-1, the output toggles and `cnt` clears.
  - Otherwise `cnt` increments.
  - `cnt` never exceeds FILTER_CYCLES-1.
  - A pulse shorter than FILTER_CYCLES samples at sync2 never reaches the output.
- **State machine:** states INIT and RUN.
  - INIT is entered on reset. It holds for FILTER_CYCLES+2 cycles, counted by an arm counter.
  - In INIT, the decoder's previous-state register tracks {out_a,out_b} every cycle. No step, illegal or position activity occurs.
  - INIT moves to RUN when the arm counter reaches FILTER_CYCLES+1.
  - RUN is left only by reset.
- **Decoder (RUN):** compares prev = {a,b} with cur = {out_a,out_b}; prev updates to cur every cycle.
  - Forward sequence: 00→10→11→01→00. On a forward step: step_valid_o=1, dir_o←1, position_o+1.
  - Reverse sequence: the reverse of the above. On a reverse step: step_valid_o=1, dir_o←0, position_o−1.
  - Both bits changed: illegal_o=1. Position and dir are unchanged.
  - No change: no pulses.
- **Arithmetic:** position wraps modulo 2^POS_WIDTH; max+1 → min.
- **Reset:** asynchronous reset at any time clears everything immediately and returns to INIT. This covers sync flops, filter counters, outputs, prev, position and error count.
- **Reset values:** every output resets to 0.
  - tachometer_out_a/b = 0.
  - dir_o = 0.
  - step_valid_o = 0.
  - position_o = 0.
  - illegal_o = 0.
  - err_count_o = 0.

## Timing
- **Filter latency:** the raw input is held at a new level; count as edge 1 the first rising edge that samples it. tachometer_out_x changes on edge FILTER_CYCLES+2. With the default of 16, that is edge 18.
- **Decoder latency:** step_valid_o, illegal_o, dir_o and position_o update on the edge after the filtered output change. End-to-end latency is FILTER_CYCLES+3 edges.
- **Pulse width:** step_valid_o and illegal_o are exactly one cycle wide. They are never asserted together.
- **Simultaneous filter flips:** if both filters flip on the same edge, the decoder sees an illegal transition.
- **Steps per cycle:** at most one step per cycle. Minimum spacing between steps is FILTER_CYCLES cycles per channel, well above encoder rates.

## Configuration
- QUAD_ERROR_COUNT_EN defined:
  - err_count_o exists.
  - It increments on each illegal_o pulse and saturates at 2^ERR_CNT_WIDTH−1.
  - It is cleared only by reset.
- QUAD_ERROR_COUNT_EN undefined:
  - Port and counter are absent.
  - illegal_o still pulses.

## Structure
- **Package `quad_pkg`:**
  - enum `quad_state_t` {INIT, RUN}.
  - localparams for the forward-sequence encodings.
  - Function `quad_step(prev,cur)` returning {+1, −1, 0, illegal}.
- **Sub-module `quad_glitch_filter`:** one instance per channel. It contains the two-flop sync and the stability counter, parameterised by FILTER_CYCLES, and exposes the filtered level.

## Test plan
- Reset, then raw A/B held at 00 for 100 cycles → all outputs 0, no pulses.
- After reset, raw = 11 → each filtered output rises on edge 18. No step or illegal pulse, because INIT is still active.
- RUN with FILTER_CYCLES=16; drive forward 00→10→11→01→00, each level held 40 cycles → 4 step pulses, dir_o=1, position_o=4, each pulse 1 edge after its filtered change. Reversing the sequence returns position_o to 0 with dir_o=0.
- Glitches on A of 15 cycles and of 16 cycles → the 15-cycle glitch produces no change on tachometer_out_a. The 16-cycle glitch produces a 16-cycle filtered pulse and two steps (+1 then −1).
- Raw 00→11 in the same cycle → illegal_o pulses once; position and dir unchanged; err_count_o=1 with QUAD_ERROR_COUNT_EN. Repeat 300 times with ERR_CNT_WIDTH=8 → err_count_o saturates at 255.
- Preload position to 2^31−1 via forward steps (POS_WIDTH=32, or a reduced width in the bench), one more forward step → position_o = −2^31. Assert reset_in mid-step → all outputs 0 asynchronously and the block re-enters INIT.

Source files
------------

// File: rtl/quad_pkg.sv
// quad_pkg: shared types and helpers for the quadrature input conditioner.
//   quad_state_t : INIT (arming after reset) / RUN (decoding).
//   quad_step_t  : classification of one {a,b} transition.
//   SEQ_0..SEQ_3 : forward-sequence encodings of {a,b}, 00 -> 10 -> 11 -> 01.
//   quad_step()  : classifies a prev -> cur transition as none / fwd / rev / illegal.
package quad_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } quad_state_t;

  typedef enum logic [1:0] {
    STEP_NONE    = 2'd0,
    STEP_FWD     = 2'd1,
    STEP_REV     = 2'd2,
    STEP_ILLEGAL = 2'd3
  } quad_step_t;

  localparam logic [1:0] SEQ_0 = 2'b00;
  localparam logic [1:0] SEQ_1 = 2'b10;
  localparam logic [1:0] SEQ_2 = 2'b11;
  localparam logic [1:0] SEQ_3 = 2'b01;

  // Position of an {a,b} code within the forward sequence (0..3).
  function automatic logic [1:0] seq_index(input logic [1:0] ab);
    case (ab)
      SEQ_0:   return 2'd0;
      SEQ_1:   return 2'd1;
      SEQ_2:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // A single-bit change moves one position around the 4-state ring; the
  // modulo-4 index difference tells forward (+1) from reverse (-1).
  function automatic quad_step_t quad_step(input logic [1:0] prev,
                                           input logic [1:0] cur);
    logic [1:0] delta;
    delta = seq_index(cur) - seq_index(prev);
    if (prev == cur)                 return STEP_NONE;
    else if ((prev ^ cur) == 2'b11)  return STEP_ILLEGAL;
    else if (delta == 2'd1)          return STEP_FWD;
    else                             return STEP_REV;
  endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// quad_glitch_filter: two-flop synchroniser plus stability counter for one
// encoder channel. The filtered level only follows the synchronised input
// after it has differed for FILTER_CYCLES consecutive samples.
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   raw   : asynchronous raw channel input
//   level : filtered channel level
module quad_glitch_filter #(
  parameter int FILTER_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // NOTE: all state in clocked blocks uses non-blocking assignments so every
  // flop samples pre-edge values; blocking here would collapse the sync chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        // The FILTER_CYCLES-th consecutive differing sample commits the change.
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/quadrature_input_conditioner.sv
// quadrature_input_conditioner: synchronises and deglitches the A/B encoder
// lines, then decodes the quadrature sequence into direction, step pulses,
// a wrapping signed position and illegal-transition pulses.
//   clk_in, reset_in               : clock, asynchronous active-high reset
//   tachometer_raw_a/b             : raw asynchronous encoder channels
//   tachometer_out_a/b             : filtered channel levels
//   dir_o                          : last legal direction (1 = forward)
//   step_valid_o / illegal_o       : one-cycle event pulses
//   position_o                     : signed step count, wraps
//   err_count_o                    : saturating illegal count, only when
//                                    QUAD_ERROR_COUNT_EN is defined
module quadrature_input_conditioner
  import quad_pkg::*;
#(
  parameter int FILTER_CYCLES = 16,
  parameter int POS_WIDTH     = 32
`ifdef QUAD_ERROR_COUNT_EN
  ,
  parameter int ERR_CNT_WIDTH = 8
`endif
) (
  input  logic                        clk_in,
  input  logic                        reset_in,
  input  logic                        tachometer_raw_a,
  input  logic                        tachometer_raw_b,
  output logic                        tachometer_out_a,
  output logic                        tachometer_out_b,
  output logic                        dir_o,
  output logic                        step_valid_o,
  output logic signed [POS_WIDTH-1:0] position_o,
  output logic                        illegal_o
`ifdef QUAD_ERROR_COUNT_EN
  ,
  output logic [ERR_CNT_WIDTH-1:0]    err_count_o
`endif
);

  localparam int ARM_W = $clog2(FILTER_CYCLES + 2);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(FILTER_CYCLES + 1);
  localparam logic [ARM_W-1:0] ARM_ONE  = ARM_W'(1);
  localparam logic signed [POS_WIDTH-1:0] POS_ONE = POS_WIDTH'(1);

  quad_state_t      state;
  logic [ARM_W-1:0] arm_cnt;
  logic [1:0]       prev_ab;
  logic [1:0]       cur_ab;
  quad_step_t       step_kind;

  quad_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter_a (
    .clk   (clk_in),
    .rst   (reset_in),
    .raw   (tachometer_raw_a),
    .level (tachometer_out_a)
  );

  quad_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter_b (
    .clk   (clk_in),
    .rst   (reset_in),
    .raw   (tachometer_raw_b),
    .level (tachometer_out_b)
  );

  assign cur_ab    = {tachometer_out_a, tachometer_out_b};
  assign step_kind = quad_step(prev_ab, cur_ab);

  // INIT lets the filters settle from their reset level before any decoding;
  // prev_ab keeps tracking the filtered inputs so RUN starts from a fresh baseline.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state        <= INIT;
      arm_cnt      <= '0;
      prev_ab      <= 2'b00;
      dir_o        <= 1'b0;
      step_valid_o <= 1'b0;
      illegal_o    <= 1'b0;
      position_o   <= '0;
    end else begin
      prev_ab      <= cur_ab;
      step_valid_o <= 1'b0;
      illegal_o    <= 1'b0;
      case (state)
        INIT: begin
          if (arm_cnt == ARM_LAST) state   <= RUN;
          else                     arm_cnt <= arm_cnt + ARM_ONE;
        end
        RUN: begin
          case (step_kind)
            STEP_FWD: begin
              step_valid_o <= 1'b1;
              dir_o        <= 1'b1;
              position_o   <= position_o + POS_ONE;
            end
            STEP_REV: begin
              step_valid_o <= 1'b1;
              dir_o        <= 1'b0;
              position_o   <= position_o - POS_ONE;
            end
            STEP_ILLEGAL: illegal_o <= 1'b1;
            default: ;
          endcase
        end
        default: state <= INIT;
      endcase
    end
  end

`ifdef QUAD_ERROR_COUNT_EN
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      err_count_o <= '0;
    end else if (illegal_o && (err_count_o != '1)) begin
      err_count_o <= err_count_o + ERR_CNT_WIDTH'(1);
    end
  end
`endif

endmodule
